// File: rtl/riscv_bus_responder.sv
// riscv_bus_responder: memory-side responder for the RISCV core bus.
// Serves a word-addressed RAM with one-cycle registered reads, plus an I/O
// region (address[31]=1) holding a console byte FIFO, a cycle counter and a
// TOHOST halt register.
// Optional feature macro: RISCV_RESPONDER_CONSOLE_EN builds the console FIFO
// and tx stream; without it the console is absent (tx tied 0, reads 0).
module riscv_bus_responder #(
  parameter int MEM_WORDS  = 4096,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        writeEnable,
  output logic [31:0] readData,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        halted,
  output logic [31:0] halt_code
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0] ram_idx;
  logic [28:0]   io_off;
  logic          is_io;
  logic          sel_console;
  logic          sel_cycle;
  logic          sel_tohost;
  logic          wr_ok;
  logic [31:0]   ram [MEM_WORDS];
  logic [31:0]   ram_q;
  logic [31:0]   io_rd_reg;
  logic [31:0]   io_rd_next;
  logic          rd_sel_ram_reg;
  logic [31:0]   cycle_reg;
  logic          halted_reg;
  logic [31:0]   halt_code_reg;
  logic [31:0]   console_rd;
  logic          addr_unused;

  assign ram_idx     = address[AW+1:2];
  assign is_io       = address[31];
  assign io_off      = address[30:2];
  assign sel_console = is_io && (io_off == 29'd0);
  assign sel_cycle   = is_io && (io_off == 29'd1);
  assign sel_tohost  = is_io && (io_off == 29'd2);
  // Stores are frozen once the core has reported halt; reads keep working.
  assign wr_ok       = writeEnable && !halted_reg;
  // Byte-lane bits are meaningless on a word bus.
  assign addr_unused = ^address[1:0];

  // RAM port: write on store cycles, registered read on load cycles (no reset).
  always_ff @(posedge clk) begin
    if (wr_ok && !is_io) ram[ram_idx] <= writeData;
    if (!writeEnable && !is_io) ram_q <= ram[ram_idx];
  end

  // I/O read data selection for the register region.
  always_comb begin
    io_rd_next = 32'd0;
    if (sel_console)     io_rd_next = console_rd;
    else if (sel_cycle)  io_rd_next = cycle_reg;
    else if (sel_tohost) io_rd_next = halt_code_reg;
  end

  // Read-side registers: remember which source answered; hold on store cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sel_ram_reg <= 1'b0;
      io_rd_reg      <= 32'd0;
    end else if (!writeEnable) begin
      rd_sel_ram_reg <= !is_io;
      io_rd_reg      <= io_rd_next;
    end
  end

  assign readData = rd_sel_ram_reg ? ram_q : io_rd_reg;

  // Free-running cycle counter and sticky TOHOST halt register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg     <= 32'd0;
      halted_reg    <= 1'b0;
      halt_code_reg <= 32'd0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (wr_ok && sel_tohost) begin
        halted_reg    <= 1'b1;
        halt_code_reg <= writeData;
      end
    end
  end

  assign halted    = halted_reg;
  assign halt_code = halt_code_reg;

`ifdef RISCV_RESPONDER_CONSOLE_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] free_cnt;
  logic          ovf_reg;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;

  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign pop      = (count_reg != '0) && tx_ready;
  assign push_req = wr_ok && sel_console;
  // A pop in the same cycle frees the slot, so a push into a full FIFO fits.
  assign push     = push_req && (!full || pop);
  assign free_cnt = CW'(FIFO_DEPTH) - count_reg;

  // FIFO storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_reg] <= writeData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_req && !push) ovf_reg <= 1'b1;
    end
  end

  assign tx_valid   = (count_reg != '0);
  assign tx_data    = tx_valid ? fifo_mem[head_reg] : 8'd0;
  assign console_rd = {ovf_reg, 23'd0, 8'(free_cnt)};
`else
  logic console_unused;

  assign console_unused = tx_ready;
  assign tx_valid       = 1'b0;
  assign tx_data        = 8'd0;
  assign console_rd     = 32'd0;
`endif

endmodule
